// File: rtl/pow2_expand_seq_pkg.sv
// Shared types and default widths for the log-to-linear expander
// and the companion exponent-finder logic.
package pow2_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } pow2_state_t;

    localparam int POW2_EXP_W  = 3;
    localparam int POW2_BASE_W = 6;
    localparam int POW2_OUT_W  = 7;

endpackage

// File: rtl/pow2_expand_seq_if.sv
// Request/result handshake bundle for pow2_expand_seq.
// master drives requests and takes results; slave is the expander.
interface pow2_expand_seq_if
    import pow2_pkg::*;
#(
    parameter int EXP_W  = POW2_EXP_W,
    parameter int BASE_W = POW2_BASE_W,
    parameter int OUT_W  = POW2_OUT_W
);

    logic              in_valid;
    logic              in_ready;
    logic [EXP_W-1:0]  in_exp;
    logic [BASE_W-1:0] in_base;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_sat;

    modport master (
        output in_valid,
        output in_exp,
        output in_base,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sat
    );

    modport slave (
        input  in_valid,
        input  in_exp,
        input  in_base,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sat
    );

endinterface

// File: rtl/pow2_expand_seq.sv
// Iterative log-to-linear expander: base << (exp + 1), one bit per
// cycle, clamping to all-ones as soon as the top bit would shift out.
module pow2_expand_seq
    import pow2_pkg::*;
#(
    parameter int EXP_W  = POW2_EXP_W,
    parameter int BASE_W = POW2_BASE_W,
    parameter int OUT_W  = POW2_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    pow2_expand_seq_if.slave io
);

    if (OUT_W < BASE_W + 1) begin : g_width_chk
        $error("pow2_expand_seq: OUT_W must be >= BASE_W + 1");
    end

    localparam logic [EXP_W:0] CNT_ONE = (EXP_W + 1)'(1);

    pow2_state_t      state;
    logic [OUT_W-1:0] acc;
    // One extra bit so the maximum code still yields 2^EXP_W shifts.
    logic [EXP_W:0]   cnt;
    logic             sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            acc   <= '0;
            cnt   <= '0;
            sat   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (io.in_valid) begin
                        acc   <= OUT_W'(io.in_base);
                        cnt   <= {1'b0, io.in_exp} + CNT_ONE;
                        sat   <= 1'b0;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // A set top bit would be lost by the next shift.
                    if (acc[OUT_W-1]) begin
                        acc   <= '1;
                        sat   <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        acc <= acc << 1;
                        cnt <= cnt - CNT_ONE;
                        if (cnt == CNT_ONE) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (io.out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign io.in_ready  = (state == S_IDLE) && !rst;
    assign io.out_valid = (state == S_DONE);
    assign io.out_data  = io.out_valid ? acc : '0;
    assign io.out_sat   = io.out_valid && sat;

endmodule

// File: doc/pow2_expand_seq.md
# pow2_expand_seq

Sequential log-to-linear expander for the neuron datapath. It accepts a small exponent code and a base magnitude, and returns `base << (exp + 1)` in a wider linear word. The shift is done iteratively, one bit position per cycle, and saturates on overflow. It converts power-of-two exponent codes from the rate/weight compression logic back into linear magnitudes, behind a valid/ready handshake on both sides.

## Interface
- `EXP_W`, default 3: exponent code width.
- `BASE_W`, default 6: base magnitude width.
- `OUT_W`, default 7: result width. Must satisfy `OUT_W >= BASE_W + 1`.
- `clk` input 1: single clock. All logic is rising-edge.
- `rst` input 1: synchronous reset, active-high.
- `in_valid` input 1: request present.
- `in_ready` output 1: block can accept a request.
- `in_exp` input EXP_W: exponent code `e`. Shift amount is `e + 1`.
- `in_base` input BASE_W: unsigned base magnitude `b`.
- `out_valid` output 1: result present.
- `out_ready` input 1: consumer takes the result.
- `out_data` output OUT_W: unsigned result, `min(b << (e+1), 2^OUT_W - 1)`.
- `out_sat` output 1: result was clipped to all-ones.

## Operation
- FSM with three states: IDLE, SHIFT, DONE.
- IDLE:
  - `in_ready = 1`.
  - On `in_valid && in_ready`: `acc <= zero-extend(b)`, `cnt <= e + 1`, `sat <= 0`, go to SHIFT.
  - `cnt` is EXP_W+1 bits wide, so `e = 2^EXP_W - 1` does not wrap.
- SHIFT: `in_ready = 0`. Each cycle does one of the following.
  - If `acc[OUT_W-1] == 1`: `acc <= all-ones`, `sat <= 1`, go to DONE (early exit).
  - Else: `acc <= acc << 1`, `cnt <= cnt - 1`. If `cnt == 1`, go to DONE.
- DONE:
  - `out_valid = 1`, `out_data = acc`, `out_sat = sat`.
  - Both outputs hold stable until `out_ready`.
  - On `out_valid && out_ready`, go to IDLE.
  - `in_ready` is not asserted in DONE; there is no same-cycle turnaround.
- `b = 0`: still performs the full `e+1` shifts. Result 0, `out_sat = 0`.
- Inputs are sampled only on the accept cycle. Changes during SHIFT/DONE are ignored.
- `in_valid` with `in_ready = 0` has no effect. The upstream must hold its request.
- All arithmetic is unsigned. There is no rounding; all shifts are logical left.

## Timing
- Reset (`rst` high at an edge): state = IDLE, `acc = 0`, `cnt = 0`, `sat = 0`.
  - `out_valid = 0`, `out_data = 0`, `out_sat = 0`.
  - `in_ready = 0` while `rst` is high, and 1 in the first cycle after `rst` deasserts.
- Reset mid-SHIFT or in DONE aborts the operation. The result is discarded and `out_valid` drops the cycle after the reset edge.
- Latency without saturation: request accepted at edge k → `out_valid` high in the cycle after edge `k + e + 1`, i.e. `e + 1` cycles of SHIFT.
- Latency with saturation: `out_valid` high in the cycle after the overflow-detect edge, which is at most `e + 1` cycles.
- Throughput: one request per `e + 3` cycles minimum (accept, shifts, DONE) with `out_ready` tied high.
- `out_valid` and `in_ready` are registered-state decodes with no combinational path from `out_ready` or `in_valid`.

## Structure
- Package `pow2_pkg`:
  - `typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} pow2_state_t`.
  - Localparam defaults `POW2_EXP_W = 3`, `POW2_BASE_W = 6`, `POW2_OUT_W = 7`, shared with the companion exponent-finder logic.
- Single module; no sub-module. The shift/saturate step is small enough to stay inline.
- Elaboration-time assertion: `OUT_W >= BASE_W + 1`.

## Test plan
- `b=1, e=0`, `out_ready=1` → `out_data=2`, `out_sat=0`, `out_valid` 1 cycle after accept.
- `b=1, e=5` → `out_data=64`, `out_sat=0`, after 6 SHIFT cycles. `b=3, e=2` → `out_data=24`, `out_sat=0`, after 3 cycles.
- `b=1, e=6` → `out_data=127`, `out_sat=1`. `b=63, e=7` → `out_data=127`, `out_sat=1`, `out_valid` 2 cycles after accept (early exit).
- `b=0, e=7` → `out_data=0`, `out_sat=0`, after exactly 8 SHIFT cycles.
- Backpressure, `b=5, e=1`:
  - Hold `out_ready=0` for 5 cycles → `out_data=20` and `out_valid` stay stable.
  - `in_ready=0` throughout, even with `in_valid=1` and changing `in_base`/`in_exp`.
  - Release → accepted next in IDLE.
- `rst` pulsed during SHIFT of `b=1, e=7` → next cycle: state IDLE, `out_valid=0`, `out_data=0`. A follow-up request `b=2, e=0` → `out_data=4`.
